// File: rtl/sweep_scheduler_if.sv
// rtl/sweep_scheduler_if.sv - request/grant/completion bundle between two requesters and the sweep scheduler
interface sweep_scheduler_if #(
  parameter int WIDTH = 8
);
  logic [1:0]         req_valid;
  logic [2*WIDTH-1:0] req_target;
  logic [1:0]         req_ready;
  logic               done;
  logic               done_id;

  modport master (
    output req_valid, req_target,
    input  req_ready, done, done_id
  );

  modport slave (
    input  req_valid, req_target,
    output req_ready, done, done_id
  );
endinterface

// File: rtl/sweep_scheduler.sv
// rtl/sweep_scheduler.sv - round-robin sweep sequencer driving an up/down counter with step pulses
// Define SWEEP_WRAP_EN for shortest-path sweeps that wrap modulo 2^WIDTH; default is linear mode.
module sweep_scheduler #(
  parameter int WIDTH    = 8,
  parameter int STEP_DIV = 1
) (
  input  logic             clk,
  input  logic             reset,
  sweep_scheduler_if.slave req,
  input  logic             clr_req,
  output logic             step,
  output logic             reverse,
  output logic             cnt_clr,
  output logic [WIDTH-1:0] position,
  output logic             busy
);
  localparam int DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(STEP_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;

  logic [WIDTH-1:0] target;
  logic             id;
  logic             rr;
  logic             clr_pend;
  logic [DIV_W-1:0] div;

  logic             grant_id;
  logic [WIDTH-1:0] grant_target;
  logic [WIDTH-1:0] pos_step;
  logic             dir_down;
  logic             at_target;
  logic             accept;

`ifdef SWEEP_WRAP_EN
  localparam logic [WIDTH-1:0] HALF = {1'b1, {(WIDTH-1){1'b0}}};
  logic [WIDTH-1:0] diff;
`endif

  always_comb begin
    grant_id     = (req.req_valid == 2'b11) ? rr : req.req_valid[1];
    grant_target = grant_id ? req.req_target[WIDTH +: WIDTH] : req.req_target[0 +: WIDTH];
    at_target    = (grant_target == position);
`ifdef SWEEP_WRAP_EN
    // Half-way distance counts as "up" so ties never reverse.
    diff     = grant_target - position;
    dir_down = (diff > HALF);
`else
    dir_down = (grant_target < position);
`endif
    pos_step = reverse ? position - 1'b1 : position + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    req.req_ready = 2'b00;
    req.done      = 1'b0;
    cnt_clr       = 1'b0;
    step          = 1'b0;
    busy          = 1'b0;
    accept        = 1'b0;
    case (state)
      IDLE: begin
        // Gated by reset so nothing is offered while reset is being sampled.
        if (!reset) begin
          if (clr_req || clr_pend) begin
            cnt_clr = 1'b1;
          end else if (req.req_valid != 2'b00) begin
            accept        = 1'b1;
            req.req_ready = grant_id ? 2'b10 : 2'b01;
            state_nx      = at_target ? DONE : RUN;
          end
        end
      end
      RUN: begin
        busy = 1'b1;
        if (div == '0) begin
          step = 1'b1;
          if (pos_step == target) state_nx = DONE;
        end
      end
      DONE: begin
        busy     = 1'b1;
        req.done = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      position <= '0;
      reverse  <= 1'b0;
      target   <= '0;
      id       <= 1'b0;
      rr       <= 1'b0;
      clr_pend <= 1'b0;
      div      <= '0;
    end else begin
      if (cnt_clr) begin
        position <= '0;
        clr_pend <= 1'b0;
      end else if (clr_req && state != IDLE) begin
        clr_pend <= 1'b1;
      end
      if (accept) begin
        target  <= grant_target;
        id      <= grant_id;
        reverse <= dir_down;
        div     <= DIV_LOAD;
      end
      if (state == RUN) div <= (div == '0) ? DIV_LOAD : div - 1'b1;
      // Shadow follows the counter, which moves on the edge that ends the step cycle.
      if (step) position <= pos_step;
      if (state == DONE) rr <= ~id;
    end
  end

  assign req.done_id = id;
endmodule

// File: tb/tb_sweep_scheduler.sv
// tb/tb_sweep_scheduler.sv - randomized self-checking bench for sweep_scheduler (STEP_DIV 1 and 3)
// Expected timing comes from a transaction-level model of accept cycle, step schedule and done cycle.
module tb_sweep_scheduler;
  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset;
  logic [1:0]     rv;
  logic [2*W-1:0] tgt;
  logic           clr;
  logic           sel;

  sweep_scheduler_if #(.WIDTH(W)) bus1 ();
  sweep_scheduler_if #(.WIDTH(W)) bus3 ();

  logic         step1, rev1, cclr1, busy1;
  logic         step3, rev3, cclr3, busy3;
  logic [W-1:0] pos1, pos3;

  assign bus1.req_valid  = sel ? 2'b00 : rv;
  assign bus1.req_target = tgt;
  assign bus3.req_valid  = sel ? rv : 2'b00;
  assign bus3.req_target = tgt;

  sweep_scheduler #(.WIDTH(W), .STEP_DIV(1)) dut1 (
    .clk(clk), .reset(reset), .req(bus1), .clr_req(sel ? 1'b0 : clr),
    .step(step1), .reverse(rev1), .cnt_clr(cclr1), .position(pos1), .busy(busy1)
  );

  sweep_scheduler #(.WIDTH(W), .STEP_DIV(3)) dut3 (
    .clk(clk), .reset(reset), .req(bus3), .clr_req(sel ? clr : 1'b0),
    .step(step3), .reverse(rev3), .cnt_clr(cclr3), .position(pos3), .busy(busy3)
  );

  logic [1:0]   o_ready;
  logic         o_step, o_rev, o_clr, o_busy, o_done, o_did;
  logic [W-1:0] o_pos;
  assign o_ready = sel ? bus3.req_ready : bus1.req_ready;
  assign o_done  = sel ? bus3.done      : bus1.done;
  assign o_did   = sel ? bus3.done_id   : bus1.done_id;
  assign o_step  = sel ? step3 : step1;
  assign o_rev   = sel ? rev3  : rev1;
  assign o_clr   = sel ? cclr3 : cclr1;
  assign o_busy  = sel ? busy3 : busy1;
  assign o_pos   = sel ? pos3  : pos1;

  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;
  int cyc = 0;
  int S = 1;
  logic [W-1:0] m_pos [2];
  bit           m_rr  [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Sweep plan: distance in steps and direction, from the mode's rules.
  function automatic void plan(input logic [W-1:0] p, input logic [W-1:0] t,
                               output int d, output bit rev);
`ifdef SWEEP_WRAP_EN
    int df;
    df = (int'(t) - int'(p) + 256) % 256;
    if (df <= 128) begin d = df; rev = 1'b0; end
    else begin d = 256 - df; rev = 1'b1; end
`else
    if (t >= p) begin d = int'(t) - int'(p); rev = 1'b0; end
    else begin d = int'(p) - int'(t); rev = 1'b1; end
`endif
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    rv    = 2'b00;
    clr   = 1'b0;
    next_cycle();
    #2;
    check("reset_outputs", {o_ready, o_step, o_rev, o_clr, o_pos, o_busy, o_done, o_did}, 32'd0);
    reset = 1'b0;
    m_pos = '{8'd0, 8'd0};
    m_rr  = '{1'b0, 1'b0};
  endtask

  task automatic do_sweep(input logic [1:0] valid, input logic [W-1:0] t0,
                          input logic [W-1:0] t1, input int clr_at_in);
    int w, d, n, k, nsteps, clr_at;
    bit rev;
    logic [W-1:0] p, t, pe;
    w = (valid == 2'b11) ? int'(m_rr[sel]) : (valid[1] ? 1 : 0);
    t = (w == 1) ? t1 : t0;
    p = m_pos[sel];
    plan(p, t, d, rev);
    clr_at = (clr_at_in > d * S + 1) ? d * S + 1 : clr_at_in;

    next_cycle();
    clr = 1'b0;
    rv  = valid;
    tgt = {t1, t0};
    k = 0;
    while (k < 4) begin
      #2;
      if (o_ready != 2'b00) break;
      next_cycle();
      k++;
    end
    check("accept_latency", k, 0);
    if (k == 4) begin
      rv = 2'b00;
      return;
    end
    check("grant", o_ready, (w == 1) ? 2'b10 : 2'b01);
    check("accept_cycle", {o_clr, o_step, o_done, o_busy, o_pos}, {4'b0000, p});
    n = cyc;

    for (int o = 1; o <= d * S + 1; o++) begin
      next_cycle();
      rv  = 2'b00;
      tgt = 16'($urandom);
      clr = (o == clr_at);
      #2;
      nsteps = ((o - 1) / S < d) ? (o - 1) / S : d;
      pe = rev ? p - W'(nsteps) : p + W'(nsteps);
      check("sweep_cycle", {o_ready, o_clr, o_step, o_done, o_busy, o_pos},
            {2'b00, 1'b0, (o % S == 0 && o <= d * S), (o == d * S + 1), 1'b1, pe});
      if (o_step) check("reverse", o_rev, rev);
    end
    check("done_cycle", cyc - n, d * S + 1);
    check("done_id", o_did, w);
    m_pos[sel] = t;
    m_rr[sel]  = (w == 0);

    if (clr_at > 0) begin
      next_cycle();
      clr = 1'b0;
      #2;
      check("pending_clear", {o_ready, o_clr, o_step, o_done, o_busy}, {2'b00, 1'b1, 3'b000});
      m_pos[sel] = '0;
    end
    clr = 1'b0;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k;
    reset = 1'b1;
    rv    = 2'b00;
    tgt   = '0;
    clr   = 1'b0;
    sel   = 1'b0;
    S     = 1;
    do_reset();

    do_sweep(2'b01, 8'd255, 8'd0, 0);
    do_sweep(2'b10, 8'd0, 8'd155, 0);

    do_reset();
    repeat (4) do_sweep(2'b11, 8'($urandom), 8'($urandom), 0);

    next_cycle();
    clr = 1'b1;
    rv  = 2'b01;
    tgt = '0;
    #2;
    check("clr_priority", {o_ready, o_clr, o_step, o_done}, {2'b00, 1'b1, 2'b00});
    m_pos[sel] = '0;
    do_sweep(2'b01, 8'd0, 8'd0, 0);
    do_sweep(2'b10, 8'd0, 8'd40, 5);

    do_sweep(2'b01, 8'd250, 8'd0, 0);
    do_sweep(2'b10, 8'd0, 8'd5, 0);

    for (int i = 0; i < 10; i++)
      do_sweep(2'($urandom_range(1, 3)), 8'($urandom), 8'($urandom),
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 40)) : 0);

    sel = 1'b1;
    S   = 3;
    do_reset();
    do_sweep(2'b01, 8'd4, 8'd0, 0);
    for (int i = 0; i < 3; i++)
      do_sweep(2'($urandom_range(1, 3)), 8'($urandom_range(0, 40)), 8'($urandom_range(0, 40)),
               ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 20)) : 0);

    do_reset();
    next_cycle();
    rv  = 2'b01;
    tgt = {8'd0, 8'd4};
    #2;
    check("midreset_grant", o_ready, 2'b01);
    k = 0;
    while (k < 30 && o_pos != 8'd2) begin
      next_cycle();
      rv = 2'b00;
      #2;
      k++;
    end
    check("midreset_pos2", o_pos, 8'd2);
    reset = 1'b1;
    next_cycle();
    #2;
    check("midreset_outputs", {o_ready, o_step, o_rev, o_clr, o_pos, o_busy, o_done, o_did}, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      next_cycle();
      #2;
      check("midreset_quiet", {o_ready, o_clr, o_step, o_done, o_busy}, 32'd0);
    end
    m_pos = '{8'd0, 8'd0};
    m_rr  = '{1'b0, 1'b0};
    do_sweep(2'b10, 8'd0, 8'd2, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/sweep_scheduler.md
# sweep_scheduler

- Sequencer and arbiter in front of the 8-bit up/down counter.
- Accepts "sweep to target" requests from two requesters and grants them round-robin.
- Drives the counter with single-cycle step pulses plus a direction bit and a clear strobe, while keeping a shadow copy of the count.
- Signals completion back to the granted requester.

## Interface
- WIDTH, 8, counter and target width
- STEP_DIV, 1, clock cycles per step pulse (>=1)

- clk  in  1  system clock, all logic rising-edge
- reset  in  1  synchronous, active-high; clears all state
- req_valid  in  2  per-requester request; held until accepted
- req_target  in  2*WIDTH  requester i target at [i*WIDTH +: WIDTH]
- clr_req  in  1  request to zero the counter
- req_ready  out  2  one-cycle accept strobe, one-hot or zero
- step  out  1  one-cycle counter advance pulse
- reverse  out  1  counter direction: 0 up, 1 down; valid whenever step=1
- cnt_clr  out  1  one-cycle counter clear pulse
- position  out  WIDTH  shadow count, equals counter value
- busy  out  1  high in RUN and DONE
- done  out  1  one-cycle completion pulse
- done_id  out  1  requester index that owns the current done

## Operation
- States: IDLE, RUN, DONE.
- IDLE
  - clr_req has priority over all requests: assert cnt_clr for one cycle, set position <= 0, stay in IDLE. No request is accepted that cycle.
  - Otherwise, if any req_valid is high, grant one requester:
    - Round-robin pointer rr selects which requester wins a tie.
    - After reset, rr favours requester 0.
    - A lone requester always wins.
  - On grant: pulse req_ready[i], latch target and id, compute direction.
- Direction (linear mode)
  - target > position: reverse=0.
  - target < position: reverse=1.
  - target == position: go directly to DONE with no steps.
  - reverse is registered and held constant for the whole sweep.
- RUN
  - Divider loads STEP_DIV-1 on entry.
  - When the divider reaches 0: pulse step, update position by ±1 in the same cycle, reload divider.
  - When the updated position equals target, go to DONE.
- DONE
  - Pulse done with done_id.
  - Set rr to point away from the id just served.
  - Return to IDLE.
- clr_req arriving in RUN or DONE is held pending and serviced on the first IDLE cycle.
- req_valid dropping after acceptance has no effect. req_target is sampled only on the accept cycle.
- Reset mid-operation
  - Abandons the sweep: no done, no step.
  - All outputs 0 on the cycle after reset is sampled high.
  - Pending clr_req is dropped.

## Timing
- Reset values: req_ready=0, step=0, reverse=0, cnt_clr=0, position=0, busy=0, done=0, done_id=0, state=IDLE, rr=0.
- Accept in cycle N (req_ready high in N).
- Distance D>0:
  - Step pulses in cycles N+k·STEP_DIV for k=1..D.
  - done in cycle N+D·STEP_DIV+1.
- D=0: done in cycle N+1, no step.
- Back-to-back: the earliest next accept is cycle done+1.
- position is registered: it reflects a step on the cycle after the step pulse, matching the counter's post-edge value.
- req_ready, step, cnt_clr and done are never high on the same cycle.

## Configuration
- SWEEP_WRAP_EN defined: shortest-path mode with wrap-around.
  - df = (target − position) mod 2^WIDTH.
  - df ≤ 2^(WIDTH−1): go up (ties go up). Otherwise go down.
  - position wraps modulo 2^WIDTH (255+1→0, 0−1→255).
- SWEEP_WRAP_EN undefined: linear mode only.
  - Direction by magnitude compare.
  - position never wraps.

## Test plan
- Reset, STEP_DIV=1, req0 target 255 from position 0 -> 255 step pulses with reverse=0, position 255, done with done_id=0 at N+256.
- Then req1 target 155 -> reverse=1, 100 steps, position 155, done_id=1.
- Both req_valid high after reset -> req0 granted first, then req1. Both reasserted -> grants continue to alternate.
- clr_req and req_valid together in IDLE -> cnt_clr pulse, position 0, request accepted on the next cycle. Request target 0 -> done at N+1, no step.
- STEP_DIV=3, target 4 from 0 -> steps at N+3, N+6, N+9, N+12, done at N+13. Reset asserted at position 2 -> next cycle all outputs 0, no done.
- Position 250, target 5:
  - With SWEEP_WRAP_EN: 11 up steps wrapping through 0.
  - Without it: 245 down steps.
